// File: rtl/key_start_ctrl.sv
// Pushbutton-triggered start controller: synchronizes and debounces Key, then
// runs one Start/Done handshake per accepted press with a bounded wait for Done.
module key_start_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Key,
    input  logic [15:0] Sw,
    input  logic        Done,
    input  logic [15:0] ResultIn,
    output logic        Start,
    output logic [15:0] DataIn,
    output logic [15:0] Result,
    output logic        ResultValid,
    output logic        Busy,
    output logic        Timeout
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    logic              sync1_q, sync2_q;
    logic              db_level_q, db_level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              press_q, press_d;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              rv_q, rv_d;
    logic              tmo_q, tmo_d;

    // Two-flop synchronizer; idles high because the key is active-low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= Key;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: level flips on the Nth consecutive differing sample; a press is its falling edge.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        press_d    = 1'b0;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level_d = sync2_q;
            db_cnt_d   = '0;
            press_d    = ~sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    // Handshake FSM; Done on the final wait cycle wins over the timeout.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        data_d   = data_q;
        result_d = result_q;
        rv_d     = rv_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    data_d  = Sw;
                    tmo_d   = 1'b0;
                    rv_d    = 1'b0;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (Done) begin
                    state_d = S_CAPTURE;
                end else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_CAPTURE: begin
                result_d = ResultIn;
                rv_d     = 1'b1;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                if (!Done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_REQ) || (state_d == S_CAPTURE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            tmo_q    <= tmo_d;
        end
    end

    assign Start       = start_q;
    assign Busy        = busy_q;
    assign DataIn      = data_q;
    assign Result      = result_q;
    assign ResultValid = rv_q;
    assign Timeout     = tmo_q;

endmodule
